// File: rtl/d_cache_nway_burst.sv
// N-way set-associative write-back / write-allocate data cache between the
// core's SRAM-style data port and an AXI burst master, with an uncached
// single-beat bypass path. One outstanding CPU request at a time.
// Ports:
//   clk, rst (async, active-low)
//   cpu_data_*   : SRAM-style request/response port of the core
//   ar*/r*       : AXI read address / read data channels
//   aw*/w*/b*    : AXI write address / write data / write response channels
module d_cache_nway_burst #(
  parameter int unsigned INDEX_WIDTH  = 7,
  parameter int unsigned OFFSET_WIDTH = 5,
  parameter int unsigned WAY_NUM      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_no_cache,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned SETS   = 1 << INDEX_WIDTH;
  localparam int unsigned WORD_W = OFFSET_WIDTH - 2;
  localparam int unsigned WORDS  = 1 << WORD_W;
  localparam int unsigned TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_WB_AW, S_WB_W, S_WB_B, S_RF_AR, S_RF_R, S_DONE,
    S_UC_AR, S_UC_R, S_UC_AW, S_UC_W, S_UC_B
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        addr_q, wdata_q;
  logic               wr_q;
  logic [1:0]         size_q;
  logic [3:0]         mask_q;
  logic [WAY_W-1:0]   victim_q;
  logic [WORD_W-1:0]  w_cnt, r_cnt;

  logic               valid_mem [WAY_NUM][SETS];
  logic               dirty_mem [WAY_NUM][SETS];
  logic [WAY_W-1:0]   ptr_mem   [SETS];
  logic [TAG_W-1:0]   tag_mem   [WAY_NUM][SETS];
  logic [31:0]        data_mem  [WAY_NUM][SETS][WORDS];

  logic [TAG_W-1:0]       tag_a;
  logic [INDEX_WIDTH-1:0] idx_a;
  logic [WORD_W-1:0]      word_a;
  logic                   hit, inv_found;
  logic [WAY_W-1:0]       hit_way, victim_c;
  logic                   hit_wr, rf_wr, done_wr;

  assign tag_a  = addr_q[31 -: TAG_W];
  assign idx_a  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign word_a = addr_q[2 +: WORD_W];

  assign cpu_data_addr_ok = cpu_data_req && rst && (state == S_IDLE);

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Tag compare and victim choice: lowest invalid way, else the set's pointer.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim_c  = ptr_mem[idx_a];
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (valid_mem[w][idx_a] && (tag_mem[w][idx_a] == tag_a)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_mem[w][idx_a] && !inv_found) begin
        inv_found = 1'b1;
        victim_c  = WAY_W'(w);
      end
    end
  end

  // Next state, bus outputs and array write strobes, all decoded from state.
  always_comb begin
    state_nxt        = state;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata  = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    hit_wr = 1'b0; rf_wr = 1'b0; done_wr = 1'b0;
    case (state)
      S_IDLE: if (cpu_data_addr_ok)
        state_nxt = cpu_data_no_cache ? (cpu_data_wr ? S_UC_AW : S_UC_AR) : S_LOOKUP;
      S_LOOKUP: begin
        if (hit) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = data_mem[hit_way][idx_a][word_a];
          hit_wr           = wr_q;
          state_nxt        = S_IDLE;
        end else if (valid_mem[victim_c][idx_a] && dirty_mem[victim_c][idx_a]) begin
          state_nxt = S_WB_AW;
        end else begin
          state_nxt = S_RF_AR;
        end
      end
      S_WB_AW: begin
        awaddr  = {tag_mem[victim_q][idx_a], idx_a, {OFFSET_WIDTH{1'b0}}};
        awlen   = 8'(WORDS - 1);
        awsize  = 3'd2;
        awvalid = 1'b1;
        if (awready) state_nxt = S_WB_W;
      end
      S_WB_W: begin
        wdata  = data_mem[victim_q][idx_a][w_cnt];
        wstrb  = 4'hF;
        wlast  = (w_cnt == WORD_W'(WORDS - 1));
        wvalid = 1'b1;
        if (wready && wlast) state_nxt = S_WB_B;
      end
      S_WB_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_RF_AR;
      end
      S_RF_AR: begin
        araddr  = {tag_a, idx_a, {OFFSET_WIDTH{1'b0}}};
        arlen   = 8'(WORDS - 1);
        arsize  = 3'd2;
        arvalid = 1'b1;
        if (arready) state_nxt = S_RF_R;
      end
      S_RF_R: begin
        rready = 1'b1;
        rf_wr  = rvalid;
        if (rvalid && rlast) state_nxt = S_DONE;
      end
      S_DONE: begin
        cpu_data_data_ok = 1'b1;
        cpu_data_rdata   = data_mem[victim_q][idx_a][word_a];
        done_wr          = wr_q;
        state_nxt        = S_IDLE;
      end
      S_UC_AR: begin
        araddr  = addr_q;
        arsize  = {1'b0, size_q};
        arvalid = 1'b1;
        if (arready) state_nxt = S_UC_R;
      end
      S_UC_R: begin
        rready = 1'b1;
        if (rvalid) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = rdata;
          state_nxt        = S_IDLE;
        end
      end
      S_UC_AW: begin
        awaddr  = addr_q;
        awsize  = {1'b0, size_q};
        awvalid = 1'b1;
        if (awready) state_nxt = S_UC_W;
      end
      S_UC_W: begin
        wdata  = wdata_q;
        wstrb  = mask_q;
        wlast  = 1'b1;
        wvalid = 1'b1;
        if (wready) state_nxt = S_UC_B;
      end
      S_UC_B: begin
        bready = 1'b1;
        if (bvalid) begin
          cpu_data_data_ok = 1'b1;
          state_nxt        = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request latch, beat counters and per-line status bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      mask_q   <= '0;
      victim_q <= '0;
      w_cnt    <= '0;
      r_cnt    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        ptr_mem[s] <= '0;
        for (int unsigned w = 0; w < WAY_NUM; w++) begin
          valid_mem[w][s] <= 1'b0;
          dirty_mem[w][s] <= 1'b0;
        end
      end
    end else begin
      state <= state_nxt;
      if (cpu_data_addr_ok) begin
        addr_q  <= cpu_data_addr;
        wdata_q <= cpu_data_wdata;
        wr_q    <= cpu_data_wr;
        size_q  <= cpu_data_size;
        mask_q  <= byte_mask(cpu_data_size, cpu_data_addr[1:0]);
      end
      if (state == S_LOOKUP && !hit) victim_q <= victim_c;
      if (hit_wr) dirty_mem[hit_way][idx_a] <= 1'b1;
      if (state == S_WB_W && wready) w_cnt <= wlast ? '0 : w_cnt + 1'b1;
      if (bready && bvalid) w_cnt <= '0;
      if (rf_wr) begin
        r_cnt <= rlast ? '0 : r_cnt + 1'b1;
        if (rlast) begin
          valid_mem[victim_q][idx_a] <= 1'b1;
          dirty_mem[victim_q][idx_a] <= 1'b0;
          // Pointer only moves when it was the one chosen, not when an invalid way was filled.
          if (victim_q == ptr_mem[idx_a])
            ptr_mem[idx_a] <= (ptr_mem[idx_a] == WAY_W'(WAY_NUM - 1)) ? '0 : ptr_mem[idx_a] + 1'b1;
        end
      end
      if (done_wr) dirty_mem[victim_q][idx_a] <= 1'b1;
    end
  end

  // Tag and data arrays; validity lives in the reset-cleared status bits.
  always_ff @(posedge clk) begin
    if (hit_wr)
      data_mem[hit_way][idx_a][word_a] <= merge_bytes(data_mem[hit_way][idx_a][word_a], wdata_q, mask_q);
    if (rf_wr)
      data_mem[victim_q][idx_a][r_cnt] <= rdata;
    if (rf_wr && rlast)
      tag_mem[victim_q][idx_a] <= tag_a;
    if (done_wr)
      data_mem[victim_q][idx_a][word_a] <= merge_bytes(data_mem[victim_q][idx_a][word_a], wdata_q, mask_q);
  end

endmodule

// File: tb/tb_d_cache_nway_burst.sv
module tb_d_cache_nway_burst;

  logic        clk, rst;
  logic        cpu_data_req, cpu_data_wr, cpu_data_no_cache;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  d_cache_nway_burst #(.INDEX_WIDTH(7), .OFFSET_WIDTH(5), .WAY_NUM(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
    .cpu_data_no_cache(cpu_data_no_cache), .cpu_data_size(cpu_data_size),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok),
    .cpu_data_data_ok(cpu_data_data_ok),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0, done_cyc = 0, r_last_cyc = 0, b_cyc = 0;

  // Scoreboard queues: expected AR/AW payloads, W beats and CPU responses.
  logic [42:0] exp_ar[$];
  logic [42:0] exp_aw[$];
  logic [36:0] exp_w[$];
  logic [32:0] exp_dat[$];

  // Memory model behind the AXI slave.
  logic [31:0] mem [logic [31:0]];
  int r_act = 0, r_idx = 0, r_len = 0, r_beat = 0, w_idx = 0, b_pend = 0;
  logic [31:0] r_base = '0, w_base = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  // AXI slave: drive at negedge, observe handshakes 1ns later (before posedge).
  always @(negedge clk) begin
    if (!rst) begin
      arready = 0; rvalid = 0; rlast = 0; rdata = 0;
      awready = 0; wready = 0; bvalid = 0;
      r_act = 0; r_idx = 0; w_idx = 0; b_pend = 0;
    end else begin
      arready = ($urandom_range(0, 3) != 0);
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      rvalid  = (r_act != 0) && ($urandom_range(0, 3) != 0);
      r_beat  = r_idx;
      rdata   = rvalid ? mem_rd(r_base + 32'(r_idx * 4)) : 32'h0;
      rlast   = rvalid && (r_idx == r_len);
      bvalid  = (b_pend != 0);
      #1;
      if (rst) begin
        if (arvalid && arready) begin
          chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
          if (exp_ar.size() != 0) chk("ar_payload", 64'({araddr, arlen, arsize}), 64'(exp_ar.pop_front()));
          r_act = 1; r_base = {araddr[31:2], 2'b00}; r_len = int'(arlen); r_idx = 0;
        end
        if (rvalid && rready) begin
          if (rlast) begin r_act = 0; r_last_cyc = cyc; end
          r_idx++;
        end
        if (awvalid && awready) begin
          chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
          if (exp_aw.size() != 0) chk("aw_payload", 64'({awaddr, awlen, awsize}), 64'(exp_aw.pop_front()));
          w_base = {awaddr[31:2], 2'b00}; w_idx = 0;
        end
        if (wvalid && wready) begin
          logic [31:0] a, v;
          chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
          if (exp_w.size() != 0) chk("w_beat", 64'({wdata, wstrb, wlast}), 64'(exp_w.pop_front()));
          a = w_base + 32'(w_idx * 4);
          v = mem_rd(a);
          for (int b = 0; b < 4; b++) if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
          mem[a] = v;
          w_idx++;
          if (wlast) b_pend = 1;
        end
        if (bvalid && bready) begin b_pend = 0; b_cyc = cyc; end
      end
    end
  end

  // CPU response monitor: pops the expected response on every data_ok.
  always @(negedge clk) begin
    logic [32:0] e;
    #1;
    if (rst && cpu_data_data_ok) begin
      chk("dok_expected", 64'(exp_dat.size() != 0), 64'd1);
      if (exp_dat.size() != 0) begin
        e = exp_dat.pop_front();
        if (e[32]) chk("rdata", 64'(cpu_data_rdata), 64'(e[31:0]));
      end
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic push_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    exp_ar.push_back({a, len, sz});
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    exp_aw.push_back({a, len, sz});
  endtask

  task automatic check_rst_outputs();
    chk("rst_ctl", 64'({cpu_data_addr_ok, cpu_data_data_ok, arvalid, rready,
                        awvalid, wvalid, wlast, bready}), 64'd0);
    chk("rst_addr", 64'({araddr, awaddr}), 64'd0);
    chk("rst_data", 64'({cpu_data_rdata, wdata}), 64'd0);
    chk("rst_len", 64'({arlen, arsize, awlen, awsize, wstrb}), 64'd0);
  endtask

  // lat: >0 cycles from addr_ok, -1 one after rlast, -2 with R beat, -3 with B, 0 unchecked.
  task automatic cpu_op(input logic wr, input logic nc, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic care, input logic [31:0] exp, input int lat);
    int n, t0, d0;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_no_cache = nc;
    cpu_data_size = sz; cpu_data_addr = a; cpu_data_wdata = wd;
    #1;
    n = 0;
    while (!cpu_data_addr_ok && n < 100) begin @(negedge clk); #1; n++; end
    chk("addr_ok", 64'(cpu_data_addr_ok), 64'd1);
    exp_dat.push_back({care, exp});
    t0 = cyc; d0 = done_cnt;
    @(negedge clk);
    cpu_data_req = 1'b0; cpu_data_addr = $urandom; cpu_data_wdata = $urandom;
    #2;
    n = 0;
    while (done_cnt == d0 && n < 400) begin @(negedge clk); #2; n++; end
    chk("data_ok_seen", 64'(done_cnt != d0), 64'd1);
    if (lat > 0)        chk("lat_hit", 64'(done_cyc - t0), 64'(lat));
    else if (lat == -1) chk("lat_rlast", 64'(done_cyc - r_last_cyc), 64'd1);
    else if (lat == -2) chk("lat_r", 64'(done_cyc - r_last_cyc), 64'd0);
    else if (lat == -3) chk("lat_b", 64'(done_cyc - b_cyc), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 8; k++) mem[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_no_cache = 1'b0;
    cpu_data_size = 2'd2; cpu_data_addr = '0; cpu_data_wdata = '0;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    cpu_data_req = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check_rst_outputs();
    cpu_data_req = 1'b0;
    rst = 1'b1;

    // Read miss then hit.
    push_ar(32'h1000, 8'd7, 3'd2);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h1004, 32'h0, 1'b1, 32'hA1, -1);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h1004, 32'h0, 1'b1, 32'hA1, 1);

    // Store byte hit, then read back merged word.
    cpu_op(1'b1, 1'b0, 2'd0, 32'h1005, 32'h0000_5500, 1'b0, 32'h0, 1);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h1004, 32'h0, 1'b1, 32'h0000_55A1, 1);

    // Fill ways 1..3 of set 0.
    for (int k = 2; k <= 4; k++) begin
      push_ar(32'(k) << 12, 8'd7, 3'd2);
      cpu_op(1'b0, 1'b0, 2'd2, 32'(k) << 12, 32'h0, 1'b1, pat(32'(k) << 12), -1);
    end

    // Conflict miss evicts dirty way 0 (line 0x1000).
    push_aw(32'h1000, 8'd7, 3'd2);
    for (int k = 0; k < 8; k++)
      exp_w.push_back({(k == 1) ? 32'h0000_55A1 : 32'hA0 + 32'(k), 4'hF, k == 7});
    push_ar(32'h5000, 8'd7, 3'd2);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h5000, 32'h0, 1'b1, pat(32'h5000), -1);

    // Write-allocate miss replaces clean way 1 (0x2000): no write-back.
    push_ar(32'h6000, 8'd7, 3'd2);
    cpu_op(1'b1, 1'b0, 2'd2, 32'h6008, 32'hDEAD_BEEF, 1'b0, 32'h0, -1);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h6008, 32'h0, 1'b1, 32'hDEAD_BEEF, 1);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h3000, 32'h0, 1'b1, pat(32'h3000), 1);

    // Uncached load and halfword store.
    push_ar(32'hBFC0_0000, 8'd0, 3'd2);
    cpu_op(1'b0, 1'b1, 2'd2, 32'hBFC0_0000, 32'h0, 1'b1, pat(32'hBFC0_0000), -2);
    push_aw(32'h1FAF_0002, 8'd0, 3'd1);
    exp_w.push_back({32'h1234_0000, 4'b1100, 1'b1});
    cpu_op(1'b1, 1'b1, 2'd1, 32'h1FAF_0002, 32'h1234_0000, 1'b0, 32'h0, -3);

    // Uncached read of a cached line goes to memory and leaves the cache intact.
    push_ar(32'h6008, 8'd0, 3'd2);
    cpu_op(1'b0, 1'b1, 2'd2, 32'h6008, 32'h0, 1'b1, pat(32'h6008), -2);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h6008, 32'h0, 1'b1, 32'hDEAD_BEEF, 1);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h5004, 32'h0, 1'b1, pat(32'h5004), 1);

    // Reset during R beat 3 of a refill.
    push_ar(32'h7000, 8'd7, 3'd2);
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_no_cache = 1'b0;
    cpu_data_size = 2'd2; cpu_data_addr = 32'h7000;
    #1;
    n = 0;
    while (!cpu_data_addr_ok && n < 100) begin @(negedge clk); #1; n++; end
    chk("addr_ok_rst_case", 64'(cpu_data_addr_ok), 64'd1);
    @(negedge clk);
    cpu_data_req = 1'b0;
    #2;
    n = 0;
    while (!(rvalid && r_beat == 3) && n < 200) begin @(negedge clk); #2; n++; end
    chk("beat3_seen", 64'(rvalid && r_beat == 3), 64'd1);
    #1;
    rst = 1'b0;
    cpu_data_req = 1'b1;
    #1;
    check_rst_outputs();
    exp_ar.delete();
    exp_dat.delete();
    repeat (2) @(negedge clk);
    #3;
    cpu_data_req = 1'b0;
    rst = 1'b1;

    // Cache was invalidated: line 0x1000 misses again and returns written-back data.
    push_ar(32'h1000, 8'd7, 3'd2);
    cpu_op(1'b0, 1'b0, 2'd2, 32'h1004, 32'h0, 1'b1, mem_rd(32'h1004), -1);
    chk("wb_mem_word", 64'(mem_rd(32'h1004)), 64'h0000_55A1);

    repeat (3) @(negedge clk);
    chk("ar_left", 64'(exp_ar.size()), 64'd0);
    chk("aw_left", 64'(exp_aw.size()), 64'd0);
    chk("w_left", 64'(exp_w.size()), 64'd0);
    chk("dat_left", 64'(exp_dat.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
